// File: rtl/polygon_edge_sequencer_pkg.sv
// polygon_edge_sequencer_pkg: FSM state codes and edge-count helper shared by the sequencer slice
package polygon_edge_sequencer_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DRAW = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;
   // a 2-vertex primitive draws one edge even when closed, to avoid retracing it backwards
   function automatic int edge_total(input int n, input logic closed);
      return (closed && n != 2) ? n : n - 1;
   endfunction
endpackage

// File: rtl/polygon_edge_sequencer_if.sv
// polygon_edge_sequencer_if: edge bus between the sequencer (master) and the line drawer (slave)
interface polygon_edge_sequencer_if #(
   parameter int COORD_W = 8,
   parameter int VCNT_W  = 4
);
   logic [COORD_W-1:0] x0, y0, x1, y1;
   logic draw_en, draw_done;
   logic [VCNT_W-1:0] edge_idx;
   modport master (output x0, y0, x1, y1, draw_en, edge_idx, input draw_done);
   modport slave (input x0, y0, x1, y1, draw_en, edge_idx, output draw_done);
endinterface

// File: rtl/polygon_edge_sequencer_vertex_store.sv
// vertex_store: parallel-load vertex register array with start/end combinational read ports
module vertex_store #(
   parameter int COORD_W   = 8,
   parameter int MAX_VERTS = 8,
   parameter int VCNT_W    = $clog2(MAX_VERTS + 1)
) (
   input  logic clk,
   input  logic n_rst,
   input  logic load,
   input  logic [2*COORD_W*MAX_VERTS-1:0] coordinates,
   input  logic [VCNT_W-1:0] rd_s,
   input  logic [VCNT_W-1:0] rd_e,
   output logic [COORD_W-1:0] s_x,
   output logic [COORD_W-1:0] s_y,
   output logic [COORD_W-1:0] e_x,
   output logic [COORD_W-1:0] e_y
);
   localparam int IW = $clog2(MAX_VERTS);
   // y above x so one vertex slice of the flat bus maps straight onto the struct
   typedef struct packed {
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] x;
   } vertex_t;
   vertex_t mem [MAX_VERTS];
   vertex_t vs, ve;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst)
         for (int k = 0; k < MAX_VERTS; k++) mem[k] <= '0;
      else if (load)
         for (int k = 0; k < MAX_VERTS; k++) mem[k] <= coordinates[2*COORD_W*k +: 2*COORD_W];
   // read indices never reach MAX_VERTS, so the low bits address the array
   assign vs = mem[rd_s[IW-1:0]];
   assign ve = mem[rd_e[IW-1:0]];
   assign s_x = vs.x;
   assign s_y = vs.y;
   assign e_x = ve.x;
   assign e_y = ve.y;
endmodule

// File: rtl/polygon_edge_sequencer.sv
// polygon_edge_sequencer: feeds polyline/polygon edges one at a time to the line drawer
module polygon_edge_sequencer
   import polygon_edge_sequencer_pkg::*;
#(
   parameter int COORD_W   = 8,
   parameter int MAX_VERTS = 8,
   parameter int VCNT_W    = $clog2(MAX_VERTS + 1)
) (
   input  logic clk,
   input  logic n_rst,
   input  logic seq_en,
   input  logic closed,
   input  logic [VCNT_W-1:0] vert_count,
   input  logic [2*COORD_W*MAX_VERTS-1:0] coordinates,
   polygon_edge_sequencer_if.master dr,
   output logic busy,
   output logic seq_done,
   output logic seq_err
);
   logic [1:0] state;
   logic [VCNT_W-1:0] edge_idx, etot, vcnt, nxt, end_idx;
   logic err, bad, start;
   logic [COORD_W-1:0] s_x, s_y, e_x, e_y;
   assign start = state == ST_IDLE && seq_en;
   assign bad = vert_count < VCNT_W'(2) || vert_count > VCNT_W'(MAX_VERTS);
   assign nxt = edge_idx + 1'b1;
   assign end_idx = nxt == vcnt ? '0 : nxt;
   vertex_store #(.COORD_W(COORD_W), .MAX_VERTS(MAX_VERTS), .VCNT_W(VCNT_W)) u_store (
      .clk(clk), .n_rst(n_rst), .load(start), .coordinates(coordinates),
      .rd_s(edge_idx), .rd_e(end_idx), .s_x(s_x), .s_y(s_y), .e_x(e_x), .e_y(e_y)
   );
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state <= ST_IDLE;
         edge_idx <= '0;
         etot <= '0;
         vcnt <= '0;
         err <= 1'b0;
      end else
         case (state)
            ST_IDLE:
               if (seq_en) begin
                  vcnt <= vert_count;
                  etot <= VCNT_W'(edge_total(int'(vert_count), closed));
                  err <= bad;
                  if (!bad) edge_idx <= '0;
                  state <= bad ? ST_DONE : ST_DRAW;
               end
            ST_DRAW:
               if (dr.draw_done) state <= edge_idx == etot - 1'b1 ? ST_DONE : ST_GAP;
            ST_GAP: begin
               edge_idx <= nxt;
               state <= ST_DRAW;
            end
            default: state <= ST_IDLE;
         endcase
   assign dr.draw_en = state == ST_DRAW;
   assign dr.x0 = dr.draw_en ? s_x : '0;
   assign dr.y0 = dr.draw_en ? s_y : '0;
   assign dr.x1 = dr.draw_en ? e_x : '0;
   assign dr.y1 = dr.draw_en ? e_y : '0;
   assign dr.edge_idx = edge_idx;
   assign busy = state != ST_IDLE;
   assign seq_done = state == ST_DONE;
   assign seq_err = seq_done && err;
endmodule
